// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit op codes and default latencies; the decode stage
// imports the same constants so both ends agree on the encoding.
package mdu_pkg;

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMthi  = 4'd5,
    OpMtlo  = 4'd6,
    OpMadd  = 4'd7,
    OpMaddu = 4'd8,
    OpMsub  = 4'd9,
    OpMsubu = 4'd10
  } mdu_op_e;

  localparam int unsigned MduMultCycles = 5;
  localparam int unsigned MduDivCycles  = 10;

  function automatic logic op_is_signed(mdu_op_e o);
    return (o == OpMult) || (o == OpDiv) || (o == OpMadd) || (o == OpMsub);
  endfunction

endpackage

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit with HI/LO registers and a fixed-latency busy window.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
module ex_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MduMultCycles,
  parameter int unsigned DIV_CYCLES  = MduDivCycles
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MulN = 4'(MULT_CYCLES);
  localparam logic [3:0] DivN = 4'(DIV_CYCLES);

  mdu_op_e     op_in;
  mdu_op_e     op_q;
  logic        busy_q;
  logic [3:0]  cnt_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q;

  logic        dec_mul, dec_div;
  logic        sgn;
  logic [63:0] ax, bx, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
  logic [63:0] res;
  logic        res_we;

  assign op_in = mdu_op_e'(op);

  // Only ops that occupy the unit are decoded here; MTHI/MTLO complete in the accept edge.
  always_comb begin
    dec_mul = 1'b0;
    dec_div = 1'b0;
    case (op_in)
      OpMult, OpMultu: dec_mul = 1'b1;
`ifdef MDU_MADD_EN
      OpMadd, OpMaddu, OpMsub, OpMsubu: dec_mul = 1'b1;
`endif
      OpDiv, OpDivu: dec_div = 1'b1;
      default: ;
    endcase
  end

  assign sgn = op_is_signed(op_q);

  // Sign/zero-extend to 64 bits so the low half of one product serves both signednesses.
  assign ax   = sgn ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign bx   = sgn ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign prod = ax * bx;

  // Signed divide via magnitudes; -2^31 / -1 falls out as 0x80000000 rem 0.
  assign a_neg  = sgn & a_q[31];
  assign b_neg  = sgn & b_q[31];
  assign a_mag  = a_neg ? (32'd0 - a_q) : a_q;
  assign b_mag  = b_neg ? (32'd0 - b_q) : b_q;
  assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    res_we = 1'b1;
    res    = prod;
    case (op_q)
      OpMult, OpMultu: res = prod;
      OpDiv, OpDivu: begin
        res    = {rem, quo};
        res_we = (b_q != 32'd0);
      end
`ifdef MDU_MADD_EN
      OpMadd, OpMaddu: res = {hi_q, lo_q} + prod;
      OpMsub, OpMsubu: res = {hi_q, lo_q} - prod;
`endif
      default: res_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      cnt_q  <= 4'd0;
      op_q   <= OpNone;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else if (busy_q) begin
      cnt_q <= cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_q <= 1'b0;
        op_q   <= OpNone;
        if (res_we) begin
          hi_q <= res[63:32];
          lo_q <= res[31:0];
        end
      end
    end else if (start) begin
      if (op_in == OpMthi) hi_q <= rs_val;
      if (op_in == OpMtlo) lo_q <= rs_val;
      if (dec_mul || dec_div) begin
        op_q   <= op_in;
        a_q    <= rs_val;
        b_q    <= rt_val;
        busy_q <= 1'b1;
        cnt_q  <= dec_div ? DivN : MulN;
      end
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Randomized self-checking bench for ex_mdu against a behavioural HI/LO model,
// plus directed cases with hand-computed results.
module tb_ex_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  // Behavioural model state
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  logic        m_we;
  int          m_left;

  ex_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_cycles(input logic [3:0] o);
    case (o)
      4'd1, 4'd2: return 5;
      4'd3, 4'd4: return 10;
`ifdef MDU_MADD_EN
      4'd7, 4'd8, 4'd9, 4'd10: return 5;
`endif
      default: return 0;
    endcase
  endfunction

  // Result is fixed at accept time: hi/lo cannot change while the unit is busy.
  task automatic model_accept();
    int sa, sb, q, r;
    longint sp;
    longint unsigned up;
    logic [63:0] acc;
    sa  = rs_val;
    sb  = rt_val;
    sp  = longint'(sa) * longint'(sb);
    up  = {32'd0, rs_val} * {32'd0, rt_val};
    acc = {m_hi, m_lo};
    m_left = exp_cycles(op);
    m_we = 1'b1;
    case (op)
      4'd5: m_hi = rs_val;
      4'd6: m_lo = rs_val;
      4'd1: m_res = sp;
      4'd2: m_res = up;
      4'd3: begin
        m_we = (rt_val != 32'd0);
        if (rs_val == 32'h8000_0000 && rt_val == 32'hffff_ffff) m_res = {32'd0, 32'h8000_0000};
        else if (m_we) begin
          q = sa / sb;
          r = sa % sb;
          m_res = {r, q};
        end
      end
      4'd4: begin
        m_we = (rt_val != 32'd0);
        if (m_we) m_res = {rs_val % rt_val, rs_val / rt_val};
      end
      4'd7: m_res = acc + sp;
      4'd8: m_res = acc + up;
      4'd9: m_res = acc - sp;
      4'd10: m_res = acc - up;
      default: m_we = 1'b0;
    endcase
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = 32'd0;
      m_lo = 32'd0;
      m_left = 0;
      m_we = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_we) {m_hi, m_lo} = m_res;
    end else if (start) begin
      model_accept();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy vs model", busy, (m_left > 0));
      check("hi vs model", hi, m_hi);
      check("lo vs model", lo, m_lo);
    end
  end

  // Called at a falling edge; the op is presented to the next rising edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op = o;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    start = 1'b0;
    op = 4'($urandom);
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  // Counts busy falling edges while scrambling operands and throwing ignored starts.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      start = ($urandom_range(0, 3) == 0);
      op = 4'($urandom);
      rs_val = $urandom;
      rt_val = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int c;
    reset = 1'b0;
    start = 1'b0;
    op = 4'd0;
    rs_val = 32'd0;
    rt_val = 32'd0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    reset = 1'b1;
    chk_en = 1'b1;

    issue(4'd1, 32'hffff_fffe, 32'd3);
    wait_idle(c);
    check("mult cycles", c, 32'd5);
    check("mult hi", hi, 32'hffff_ffff);
    check("mult lo", lo, 32'hffff_fffa);

    issue(4'd4, 32'd7, 32'd2);
    wait_idle(c);
    check("divu cycles", c, 32'd10);
    check("divu lo", lo, 32'd3);
    check("divu hi", hi, 32'd1);

    issue(4'd3, 32'hffff_fff9, 32'd2);
    wait_idle(c);
    check("div lo", lo, 32'hffff_fffd);
    check("div hi", hi, 32'hffff_ffff);

    issue(4'd5, 32'h1234, 32'd0);
    check("mthi hi", hi, 32'h1234);
    check("mthi busy", busy, 32'd0);
    issue(4'd3, 32'd99, 32'd0);
    wait_idle(c);
    check("div0 cycles", c, 32'd10);
    check("div0 hi", hi, 32'h1234);
    check("div0 lo", lo, 32'hffff_fffd);

    issue(4'd2, 32'hffff_ffff, 32'hffff_ffff);
    start = 1'b1;
    op = 4'd4;
    rs_val = 32'd5;
    rt_val = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(c);
    check("multu cycles", c + 1, 32'd5);
    check("multu hi", hi, 32'hffff_fffe);
    check("multu lo", lo, 32'h0000_0001);

    issue(4'd3, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async rst busy", busy, 32'd0);
    check("async rst hi", hi, 32'd0);
    check("async rst lo", lo, 32'd0);
    #1;
    reset = 1'b1;
    start = 1'b1;
    op = 4'd2;
    rs_val = 32'd6;
    rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check("first op after reset", busy, 32'd1);
    wait_idle(c);
    check("post-reset cycles", c, 32'd5);
    check("post-reset lo", lo, 32'd42);

    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'd5, 32'd0);
    issue(4'd7, 32'd2, 32'd3);
`ifdef MDU_MADD_EN
    check("madd busy", busy, 32'd1);
    wait_idle(c);
    check("madd lo", lo, 32'd11);
    check("madd hi", hi, 32'd0);
`else
    check("madd busy", busy, 32'd0);
    @(negedge clk);
    check("madd lo", lo, 32'd5);
`endif

    for (int i = 0; i < 250; i++) begin
      logic [3:0]  o;
      logic [31:0] a, b;
      int n;
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin
          a = 32'h8000_0000;
          b = 32'hffff_ffff;
        end
        2: b = $urandom_range(1, 9);
        default: ;
      endcase
      issue(o, a, b);
      wait_idle(n);
      check("rand cycles", n, exp_cycles(o));
    end

    issue(4'd3, 32'h8000_0000, 32'hffff_ffff);
    wait_idle(c);
    check("div ovf lo", lo, 32'h8000_0000);
    check("div ovf hi", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 Parameter: MULT_CYCLES, 5, busy duration in cycles for multiply-class ops (legal range 1..15).
REQ-002 Parameter: DIV_CYCLES, 10, busy duration in cycles for divide-class ops (legal range 1..15).
REQ-003 The block SHALL have one clock, clk; reset is asynchronous and active-low.
REQ-004 Port list:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, valid MDU op in EX this cycle.
- op, input, 4, op code from the shared package.
- rs_val, input, 32, forwarded EX operand A.
- rt_val, input, 32, forwarded EX operand B.
- busy, output, 1, registered; operation in flight.
- hi, output, 32, registered HI.
- lo, output, 32, registered LO.

Function
REQ-005 Op codes SHALL be NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10; codes 11..15 and NONE are no-ops.
REQ-006 Accept condition: start=1 and busy=0 at a rising edge; start while busy=1 SHALL be ignored, and hi, lo and the counter are unchanged.
REQ-007 Accepted MTHI/MTLO SHALL write rs_val to hi/lo at that same edge; busy stays 0.
REQ-008 Accepted multiply-class or divide-class op SHALL latch rs_val, rt_val and op, load the counter with N, and set busy=1 at that edge.
- N = MULT_CYCLES for MULT, MULTU, MADD, MADDU, MSUB, MSUBU.
- N = DIV_CYCLES for DIV, DIVU.
REQ-009 busy SHALL stay 1 for exactly N cycles; the counter decrements by 1 each edge.
REQ-010 At the edge where the counter reaches 0, busy SHALL clear and hi/lo SHALL update in that same edge; a new op may be accepted on the following edge.
REQ-011 MULT/MULTU: {hi,lo} = 64-bit signed/unsigned product of the latched operands.
REQ-012 DIV/DIVU: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend; signed or unsigned per op.
REQ-013 Divide by zero: hi and lo SHALL remain unchanged, but busy still runs for DIV_CYCLES.
REQ-014 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-015 Results SHALL be computed from the latched operands only; changes on rs_val/rt_val while busy SHALL have no effect.

Reset
REQ-016 reset low SHALL asynchronously force busy=0, hi=0, lo=0, counter=0 and latched op=NONE, including mid-operation; the pending result is discarded.
REQ-017 The first op SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-018 Macro MDU_MADD_EN:
- Defined: MADD/MADDU/MSUB/MSUBU SHALL add (MADD/MADDU) or subtract (MSUB/MSUBU) the signed/unsigned product to/from the {hi,lo} value held at completion, modulo 2^64.
- Undefined: codes 7..10 SHALL be treated as no-ops and never assert busy.

Structure
REQ-019 The op-code constants and the MULT_CYCLES/DIV_CYCLES defaults SHALL live in the shared package mdu_pkg; the decode stage uses the same constants.
REQ-020 The block is a single module with no sub-module; the 4-bit counter, the operand/op latches and the result datapath are all inline.

Verification
REQ-021 Verification SHALL cover at least these directed scenarios:
- MULT with rs=0xFFFFFFFE (-2), rt=3: busy high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIVU with rs=7, rt=2: busy high for exactly 10 cycles, then lo=3, hi=1; DIV with rs=-7, rt=2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MTHI with rs=0x1234 then DIV with rt=0: hi=0x1234 after the MTHI edge, and hi/lo unchanged after the 10 busy cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, with a second start pulse mid-busy: the second pulse is ignored; hi=0xFFFFFFFE, lo=0x00000001.
- reset pulsed low at busy cycle 3 of a DIV: busy, hi and lo are 0 immediately, before the next clock edge.
- With MDU_MADD_EN: hi=0, lo=5, then MADD 2x3 gives lo=11; without the macro, the same stimulus leaves busy=0 and lo=5.
